// File: rtl/lsu_sequencer.sv
// ---------------------------------------------------------------------------
// lsu_sequencer
//
// Multi-cycle load/store sequencer sitting between the EX stage and the
// data-memory bus. One access is accepted per request. The sequencer issues a
// word-aligned bus request with byte enables and lane-replicated store data,
// then waits for bus_ack. If no ack arrives in time, the access finishes with
// an error. The pipeline is stalled while the access is outstanding. Load
// data is returned sign- or zero-extended according to funct3.
//
// Parameters
//   TIMEOUT_CYCLES : max cycles in REQ without bus_ack (0 = never time out)
//   CNT_W          : width of the timeout counter, must hold TIMEOUT_CYCLES
//
// Configuration macro
//   MISALIGN_EXC_EN : when defined, a misaligned H/HU/W access completes
//                     immediately with misalign=1 and issues no bus cycle.
//                     When undefined, the offending low address bits are
//                     ignored and misalign is tied to 0.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start           : EX-stage instruction valid
//   mem_read        : load instruction
//   mem_write       : store instruction (wins if both are set)
//   rm_type         : funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr, wdata     : effective address, store data (rs2)
//   stall           : hold pipeline
//   done            : one-cycle completion pulse
//   rdata           : extended load data, valid with done
//   err             : bus timeout or illegal rm_type, valid with done
//   misalign        : misaligned access, valid with done
//   bus_req .. bus_wdata : request side of the data-memory bus
//   bus_ack, bus_rdata   : slave response (1-cycle ack, data with ack)
// ---------------------------------------------------------------------------
module lsu_sequencer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  rm_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        misalign,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] RM_B  = 3'b000;
   localparam logic [2:0] RM_H  = 3'b001;
   localparam logic [2:0] RM_W  = 3'b010;
   localparam logic [2:0] RM_BU = 3'b100;
   localparam logic [2:0] RM_HU = 3'b101;

   // The counter holds the number of REQ cycles already spent; the last
   // allowed REQ cycle is the one where it equals TIMEOUT_CYCLES-1, so
   // bus_req is high for exactly TIMEOUT_CYCLES cycles on a timeout.
   localparam int              TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);
   localparam bit              TO_EN     = (TIMEOUT_CYCLES > 0);

   state_t            state_q;
   state_t            state_d;

   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        type_q;
   logic              we_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [31:0]       rdata_q;
   logic              err_q;
   logic              misalign_q;

   logic              access;
   logic              in_illegal;
   logic              in_misalign;
   logic              timeout;

   logic [3:0]        be_c;
   logic [31:0]       wdata_rep;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       load_ext;

   assign access  = start & (mem_read | mem_write);
   assign timeout = TO_EN && (cnt_q == TO_LAST);

   // Unsigned sizes only exist for loads; 011/110/111 are never legal.
   always_comb begin
      in_illegal = 1'b0;
      case (rm_type)
         RM_B, RM_H, RM_W: in_illegal = 1'b0;
         RM_BU, RM_HU:     in_illegal = mem_write;
         default:          in_illegal = 1'b1;
      endcase
   end

`ifdef MISALIGN_EXC_EN
   always_comb begin
      in_misalign = 1'b0;
      case (rm_type)
         RM_H, RM_HU: in_misalign = addr[0];
         RM_W:        in_misalign = (addr[1:0] != 2'b00);
         default:     in_misalign = 1'b0;
      endcase
   end
`else
   assign in_misalign = 1'b0;
`endif

   // Byte enables and store-lane replication from the latched request.
   // Halfwords look only at addr[1] and words ignore addr[1:0], which is
   // what makes the non-exception build drop the offending low bits.
   always_comb begin
      be_c      = 4'b1111;
      wdata_rep = wdata_q;
      case (type_q)
         RM_B, RM_BU: begin
            be_c      = 4'b0001 << addr_q[1:0];
            wdata_rep = {4{wdata_q[7:0]}};
         end
         RM_H, RM_HU: begin
            be_c      = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane extraction and extension of the returned read word.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    ld_byte = bus_rdata[7:0];
         2'd1:    ld_byte = bus_rdata[15:8];
         2'd2:    ld_byte = bus_rdata[23:16];
         default: ld_byte = bus_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (type_q)
         RM_B:    load_ext = {{24{ld_byte[7]}}, ld_byte};
         RM_BU:   load_ext = {24'd0, ld_byte};
         RM_H:    load_ext = {{16{ld_half[15]}}, ld_half};
         RM_HU:   load_ext = {16'd0, ld_half};
         default: load_ext = bus_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Illegal and (optionally) misaligned accesses skip
   // the bus entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               state_d = (in_illegal || in_misalign) ? DONE : REQ;
            end
         end
         REQ: begin
            if (bus_ack || timeout) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch, timeout counter and completion status. The status
   // registers are rewritten every cycle so they only carry a value during
   // the DONE cycle that follows the transition that set them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         type_q     <= '0;
         we_q       <= 1'b0;
         cnt_q      <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         if (state_q == IDLE && access) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            type_q  <= rm_type;
            we_q    <= mem_write;
         end

         if (state_q == REQ) begin
            cnt_q <= cnt_q + 1'b1;
         end else begin
            cnt_q <= '0;
         end

         rdata_q    <= '0;
         err_q      <= 1'b0;
         misalign_q <= 1'b0;
         if (state_q == IDLE && access) begin
            err_q      <= in_illegal;
            misalign_q <= !in_illegal && in_misalign;
         end else if (state_q == REQ) begin
            if (bus_ack) begin
               rdata_q <= we_q ? 32'd0 : load_ext;
            end else if (timeout) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   // Output decode. Bus fields are driven only while the request is up.
   // stall is qualified with rst_n so it drops as soon as reset asserts.
   always_comb begin
      stall     = 1'b0;
      done      = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = '0;
      bus_be    = '0;
      bus_wdata = '0;
      case (state_q)
         IDLE: stall = access & rst_n;
         REQ: begin
            stall     = 1'b1;
            bus_req   = 1'b1;
            bus_we    = we_q;
            bus_addr  = {addr_q[31:2], 2'b00};
            bus_be    = be_c;
            bus_wdata = wdata_rep;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign rdata    = rdata_q;
   assign err      = err_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lsu_sequencer
//
// Self-checking bench for lsu_sequencer. Directed scenarios cover the
// documented examples; a randomized loop compares the DUT against a
// byte-lane reference model. The DUT runs with TIMEOUT_CYCLES=4.
// ---------------------------------------------------------------------------
module tb_lsu_sequencer;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  rm_type = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        err;
   logic        misalign;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'd0;

   int errors = 0;
   int checks = 0;

   // Observations from the most recent access.
   int          o_done_cyc;
   int          o_req_cyc;
   logic [31:0] o_rdata;
   logic        o_err;
   logic        o_mis;
   logic        o_we;
   logic [31:0] o_addr;
   logic [3:0]  o_be;
   logic [31:0] o_wd;
   bit          o_const_ok;
   bit          o_stall_ok;
   bit          o_pulse_ok;

   // Reference model expectations.
   int          e_done_cyc;
   int          e_req_cyc;
   logic [31:0] e_rdata;
   logic        e_err;
   logic        e_mis;
   logic [3:0]  e_be;
   logic [31:0] e_wd;

   lsu_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .rm_type   (rm_type),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .misalign  (misalign),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_be    (bus_be),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Behavioural model: access size in bytes, lane offset, masks and shifts.
   // ack_at = 0 means the slave never answers.
   function automatic void ref_model(input logic wr, input logic [2:0] t,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     input logic [31:0] rb, input int ack_at);
      int          sz;
      int          off;
      logic [31:0] mask;
      logic [31:0] v;
      bit          illegal;
      bit          mis;
      illegal = (t == 3'd3) || (t == 3'd6) || (t == 3'd7) || (wr && (t == 3'd4 || t == 3'd5));
      sz = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
      mis = 1'b0;
`ifdef MISALIGN_EXC_EN
      mis = !illegal && (sz > 1) && ((a % sz) != 0);
`endif
      off  = int'(a % 4) / sz * sz;
      e_be = 4'(((1 << sz) - 1) << off);
      e_wd = 32'd0;
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
      v    = (rb >> (8*off)) & mask;
      if (!t[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      e_err = 1'b0;
      e_mis = 1'b0;
      e_rdata = 32'd0;
      if (illegal) begin
         e_done_cyc = 1; e_req_cyc = 0; e_err = 1'b1;
      end else if (mis) begin
         e_done_cyc = 1; e_req_cyc = 0; e_mis = 1'b1;
      end else if (ack_at == 0) begin
         e_done_cyc = TO + 1; e_req_cyc = TO; e_err = 1'b1;
      end else begin
         e_done_cyc = ack_at + 1; e_req_cyc = ack_at;
         e_rdata = wr ? 32'd0 : v;
      end
   endfunction

   // Drives one access starting at a negedge (cycle 0) and records what the
   // DUT does until done, plus one cycle after. Returns at the negedge of the
   // cycle after done, so consecutive calls are back-to-back.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rb, input int ack_at, input bit noise);
      int   n;
      logic s_done, s_req, s_stall;
      o_done_cyc = -1; o_req_cyc = 0; o_rdata = '0; o_err = 0; o_mis = 0;
      o_we = 0; o_addr = '0; o_be = '0; o_wd = '0;
      o_const_ok = 1; o_stall_ok = 1; o_pulse_ok = 1;
      start = 1; mem_read = rd; mem_write = wr; rm_type = t; addr = a; wdata = wd;
      bus_ack = 0;
      #1;
      if (stall !== 1'b1) o_stall_ok = 0;
      n = 0;
      while (o_done_cyc < 0 && n < 40) begin
         @(negedge clk);
         n++;
         s_done = done; s_req = bus_req; s_stall = stall;
         if (s_done === 1'b1) begin
            o_done_cyc = n; o_rdata = rdata; o_err = err; o_mis = misalign;
            if (s_stall !== 1'b0 || s_req !== 1'b0) o_stall_ok = 0;
         end else if (s_req === 1'b1) begin
            o_req_cyc++;
            if (s_stall !== 1'b1) o_stall_ok = 0;
            if (o_req_cyc == 1) begin
               o_we = bus_we; o_addr = bus_addr; o_be = bus_be; o_wd = bus_wdata;
            end else if (bus_we !== o_we || bus_addr !== o_addr || bus_be !== o_be || bus_wdata !== o_wd) begin
               o_const_ok = 0;
            end
         end else begin
            o_stall_ok = 0;
         end
         // Inputs for the next edge. Garbage on start/operands while busy
         // must be ignored; a stray ack in DONE must be ignored too.
         if (noise) begin
            start = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            rm_type = 3'($urandom); addr = $urandom; wdata = $urandom;
         end else begin
            start = 0;
         end
         bus_ack = 0;
         bus_rdata = $urandom;
         if (s_done === 1'b1) begin
            start = 0;
            bus_ack = noise ? 1'($urandom) : 1'b0;
         end else if (s_req === 1'b1 && o_req_cyc == ack_at) begin
            bus_ack = 1; bus_rdata = rb;
         end
      end
      @(negedge clk);
      if (done !== 1'b0 || bus_req !== 1'b0) o_pulse_ok = 0;
      bus_ack = 0;
   endtask

   task automatic test_reset();
      #12;
      if ({stall, done, err, misalign, bus_req, bus_we} !== 6'b0) begin
         errors++; $display("[TB] FAIL reset_ctrl: got %b want 000000", {stall, done, err, misalign, bus_req, bus_we});
      end
      checks++;
      if ({rdata, bus_addr, bus_wdata, bus_be} !== 100'd0) begin
         errors++; $display("[TB] FAIL reset_data: rdata=%h addr=%h wdata=%h be=%b want all 0", rdata, bus_addr, bus_wdata, bus_be);
      end
      checks++;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_lw();
      run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4, 0);
      if (o_done_cyc !== 5) begin errors++; $display("[TB] FAIL lw_done_cycle: got %0d want 5", o_done_cyc); end
      checks++;
      if (o_req_cyc !== 4) begin errors++; $display("[TB] FAIL lw_req_cycles: got %0d want 4", o_req_cyc); end
      checks++;
      if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin
         errors++; $display("[TB] FAIL lw_bus: addr=%h be=%b we=%b want 00000100 1111 0", o_addr, o_be, o_we);
      end
      checks++;
      if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin
         errors++; $display("[TB] FAIL lw_rdata: got %h err=%b want deadbeef err=0", o_rdata, o_err);
      end
      checks++;
      if (!(o_stall_ok && o_const_ok && o_pulse_ok)) begin
         errors++; $display("[TB] FAIL lw_handshake: stall_ok=%0d const_ok=%0d pulse_ok=%0d want 1 1 1", o_stall_ok, o_const_ok, o_pulse_ok);
      end
      checks++;
   endtask

   task automatic test_lb_lbu();
      run_access(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 1, 0);
      if (o_be !== 4'b1000 || o_addr !== 32'h200) begin
         errors++; $display("[TB] FAIL lb_bus: be=%b addr=%h want 1000 00000200", o_be, o_addr);
      end
      checks++;
      if (o_rdata !== 32'hFFFF_FF80 || o_done_cyc !== 2) begin
         errors++; $display("[TB] FAIL lb_rdata: got %h at cycle %0d want ffffff80 at 2", o_rdata, o_done_cyc);
      end
      checks++;
      run_access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 1, 0);
      if (o_rdata !== 32'h0000_0080 || o_be !== 4'b1000) begin
         errors++; $display("[TB] FAIL lbu_rdata: got %h be=%b want 00000080 1000", o_rdata, o_be);
      end
      checks++;
   endtask

   task automatic test_sh();
      @(negedge clk);
      run_access(0, 1, 3'b001, 32'h12, 32'h0000_ABCD, 32'h5555_5555, 2, 0);
      if (o_we !== 1'b1 || o_be !== 4'b1100 || o_addr !== 32'h10) begin
         errors++; $display("[TB] FAIL sh_bus: we=%b be=%b addr=%h want 1 1100 00000010", o_we, o_be, o_addr);
      end
      checks++;
      if (o_wd !== 32'hABCD_ABCD) begin errors++; $display("[TB] FAIL sh_wdata: got %h want abcdabcd", o_wd); end
      checks++;
      if (o_rdata !== 32'd0 || o_done_cyc !== 3) begin
         errors++; $display("[TB] FAIL sh_done: rdata=%h cycle=%0d want 00000000 at 3", o_rdata, o_done_cyc);
      end
      checks++;
   endtask

   task automatic test_timeout();
      @(negedge clk);
      run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 0);
      if (o_req_cyc !== TO || o_done_cyc !== TO + 1) begin
         errors++; $display("[TB] FAIL timeout_len: req=%0d done=%0d want %0d %0d", o_req_cyc, o_done_cyc, TO, TO + 1);
      end
      checks++;
      if (o_err !== 1'b1 || o_rdata !== 32'd0) begin
         errors++; $display("[TB] FAIL timeout_err: err=%b rdata=%h want 1 00000000", o_err, o_rdata);
      end
      checks++;
      run_access(1, 0, 3'b010, 32'h304, 32'h0, 32'h1357_9BDF, 1, 0);
      if (o_err !== 1'b0 || o_rdata !== 32'h1357_9BDF || o_done_cyc !== 2) begin
         errors++; $display("[TB] FAIL timeout_recover: err=%b rdata=%h cycle=%0d want 0 13579bdf 2", o_err, o_rdata, o_done_cyc);
      end
      checks++;
   endtask

   task automatic test_misalign();
      @(negedge clk);
      run_access(1, 0, 3'b001, 32'h101, 32'h0, 32'h1234_8765, 1, 0);
`ifdef MISALIGN_EXC_EN
      if (o_req_cyc !== 0 || o_done_cyc !== 1 || o_mis !== 1'b1 || o_rdata !== 32'd0) begin
         errors++; $display("[TB] FAIL lh_misalign: req=%0d cycle=%0d mis=%b rdata=%h want 0 1 1 00000000", o_req_cyc, o_done_cyc, o_mis, o_rdata);
      end
`else
      if (o_be !== 4'b0011 || o_mis !== 1'b0 || o_rdata !== 32'hFFFF_8765 || o_done_cyc !== 2) begin
         errors++; $display("[TB] FAIL lh_misalign: be=%b mis=%b rdata=%h cycle=%0d want 0011 0 ffff8765 2", o_be, o_mis, o_rdata, o_done_cyc);
      end
`endif
      checks++;
   endtask

   task automatic test_illegal();
      @(negedge clk);
      run_access(1, 0, 3'b011, 32'h40, 32'h0, 32'h0, 1, 0);
      if (o_err !== 1'b1 || o_req_cyc !== 0 || o_done_cyc !== 1) begin
         errors++; $display("[TB] FAIL illegal_011: err=%b req=%0d cycle=%0d want 1 0 1", o_err, o_req_cyc, o_done_cyc);
      end
      checks++;
      run_access(0, 1, 3'b100, 32'h40, 32'hFF, 32'h0, 1, 0);
      if (o_err !== 1'b1 || o_req_cyc !== 0) begin
         errors++; $display("[TB] FAIL illegal_store_bu: err=%b req=%0d want 1 0", o_err, o_req_cyc);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1; mem_read = 1; mem_write = 0; rm_type = 3'b010; addr = 32'h40;
      @(negedge clk);
      start = 0; mem_read = 0;
      @(negedge clk);
      if (bus_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre: bus_req=%b want 1", bus_req); end
      checks++;
      #2 rst_n = 0;
      #1;
      if (bus_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_mid_drop: req=%b stall=%b done=%b want 0 0 0", bus_req, stall, done);
      end
      checks++;
      @(negedge clk);
      rst_n = 1; bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus_ack = 0;
      if (done !== 1'b0 || bus_req !== 1'b0 || rdata !== 32'd0) begin
         errors++; $display("[TB] FAIL rst_late_ack: done=%b req=%b rdata=%h want 0 0 00000000", done, bus_req, rdata);
      end
      checks++;
      @(negedge clk);
      run_access(1, 0, 3'b101, 32'h42, 32'h0, 32'h9ABC_0000, 2, 0);
      if (o_rdata !== 32'h0000_9ABC || o_be !== 4'b1100 || o_err !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_after_lhu: rdata=%h be=%b err=%b want 00009abc 1100 0", o_rdata, o_be, o_err);
      end
      checks++;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      run_access(0, 1, 3'b000, 32'h501, 32'h0000_00A5, 32'h0, 1, 0);
      if (o_be !== 4'b0010 || o_wd !== 32'hA5A5_A5A5 || o_done_cyc !== 2) begin
         errors++; $display("[TB] FAIL b2b_first: be=%b wd=%h cycle=%0d want 0010 a5a5a5a5 2", o_be, o_wd, o_done_cyc);
      end
      checks++;
      run_access(1, 1, 3'b010, 32'h600, 32'h1122_3344, 32'h0, 1, 0);
      if (o_we !== 1'b1 || o_wd !== 32'h1122_3344 || o_done_cyc !== 2 || !o_stall_ok) begin
         errors++; $display("[TB] FAIL b2b_second: we=%b wd=%h cycle=%0d stall_ok=%0d want 1 11223344 2 1", o_we, o_wd, o_done_cyc, o_stall_ok);
      end
      checks++;
   endtask

   task automatic test_random();
      logic        rd, wr;
      logic [2:0]  t;
      logic [31:0] a, wd, rb;
      int          ack;
      bit          nz;
      @(negedge clk);
      for (int k = 0; k < 60; k++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if (!rd && !wr) rd = 1;
         t   = 3'($urandom_range(0, 7));
         a   = $urandom;
         wd  = $urandom;
         rb  = $urandom;
         ack = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
         nz  = 1'($urandom_range(0, 1));
         ref_model(wr, t, a, wd, rb, ack);
         run_access(rd, wr, t, a, wd, rb, ack, nz);
         if (o_done_cyc !== e_done_cyc || o_req_cyc !== e_req_cyc) begin
            errors++; $display("[TB] FAIL rnd_timing[%0d]: done=%0d req=%0d want %0d %0d", k, o_done_cyc, o_req_cyc, e_done_cyc, e_req_cyc);
         end
         checks++;
         if (o_rdata !== e_rdata || o_err !== e_err || o_mis !== e_mis) begin
            errors++; $display("[TB] FAIL rnd_result[%0d]: rdata=%h err=%b mis=%b want %h %b %b", k, o_rdata, o_err, o_mis, e_rdata, e_err, e_mis);
         end
         checks++;
         if (!(o_stall_ok && o_const_ok && o_pulse_ok)) begin
            errors++; $display("[TB] FAIL rnd_handshake[%0d]: stall_ok=%0d const_ok=%0d pulse_ok=%0d want 1 1 1", k, o_stall_ok, o_const_ok, o_pulse_ok);
         end
         checks++;
         if (e_req_cyc > 0) begin
            if (o_be !== e_be || o_addr !== {a[31:2], 2'b00} || o_we !== wr) begin
               errors++; $display("[TB] FAIL rnd_bus[%0d]: be=%b addr=%h we=%b want %b %h %b", k, o_be, o_addr, o_we, e_be, {a[31:2], 2'b00}, wr);
            end
            checks++;
            if (wr && o_wd !== e_wd) begin
               errors++; $display("[TB] FAIL rnd_wdata[%0d]: got %h want %h", k, o_wd, e_wd);
            end
            if (wr) checks++;
         end
      end
      start = 0; mem_read = 0; mem_write = 0;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh();
      test_timeout();
      test_misalign();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
